// File: rtl/hex_pattern_decoder.sv
// hex_pattern_decoder
//   Recovers the hex nibble shown on each of NUM_DIGITS active-low 7-segment
//   digits. The flow for one transaction is:
//     1. snapshot the inputs on start;
//     2. decode one digit per cycle into shadow registers;
//     3. require STABLE_CYCLES consecutive matches of the live input against
//        the snapshot, re-snapshotting up to MAX_RETRIES times on a mismatch;
//     4. present the result with a valid/ready handshake.
//
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   hex_in     NUM_DIGITS*7 segment patterns, digit i at [7i+6:7i], bit0 = seg a
//   start      request a decode (sampled in IDLE only)
//   busy       high whenever not IDLE
//   out_valid  result available (PRESENT)
//   out_ready  consumer accepts the result
//   value_out  decoded nibbles, digit i at [4i+3:4i]
//   digit_err  per-digit illegal-pattern flag
//   unstable   result given up after MAX_RETRIES mismatches
module hex_pattern_decoder #(
  parameter int NUM_DIGITS    = 6,
  parameter int STABLE_CYCLES = 4,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_DIGITS*7-1:0] hex_in,
  input  logic                    start,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_DIGITS*4-1:0] value_out,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    unstable
);

  localparam int IW = (NUM_DIGITS > 1)    ? $clog2(NUM_DIGITS)      : 1;
  localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES)   : 1;
  localparam int RW = (MAX_RETRIES > 0)   ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [SW-1:0] LAST_STB = SW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RET_MAX  = RW'(MAX_RETRIES);

  typedef enum logic [1:0] {IDLE, SCAN, VERIFY, PRESENT} state_t;

  state_t                         state_q, state_d;
  logic [NUM_DIGITS-1:0][6:0]     snap_q;
  logic [NUM_DIGITS-1:0][3:0]     shv_q;
  logic [NUM_DIGITS-1:0]          she_q;
  logic [NUM_DIGITS-1:0][3:0]     val_q;
  logic [NUM_DIGITS-1:0]          err_q;
  logic                           unst_q;
  logic [IW-1:0]                  idx_q;
  logic [SW-1:0]                  stb_q;
  logic [RW-1:0]                  ret_q;

  logic                           match;
  logic [6:0]                     cur_seg;
  logic [4:0]                     dec;       // {err, nibble}

  // Pattern -> {err, nibble}; anything not in the table (blank included)
  // decodes to 0 with err set.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'h40: seg_decode = 5'h00;
      7'h79: seg_decode = 5'h01;
      7'h24: seg_decode = 5'h02;
      7'h30: seg_decode = 5'h03;
      7'h19: seg_decode = 5'h04;
      7'h12: seg_decode = 5'h05;
      7'h02: seg_decode = 5'h06;
      7'h78: seg_decode = 5'h07;
      7'h00: seg_decode = 5'h08;
      7'h10: seg_decode = 5'h09;
      7'h08: seg_decode = 5'h0A;
      7'h03: seg_decode = 5'h0B;
      7'h46: seg_decode = 5'h0C;
      7'h21: seg_decode = 5'h0D;
      7'h06: seg_decode = 5'h0E;
      7'h0E: seg_decode = 5'h0F;
      default: seg_decode = 5'h10;
    endcase
  endfunction

  assign match   = (hex_in == snap_q);
  assign cur_seg = snap_q[idx_q];
  assign dec     = seg_decode(cur_seg);

  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == PRESENT);
  assign value_out = val_q;
  assign digit_err = err_q;
  assign unstable  = unst_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (idx_q == LAST_IDX) state_d = VERIFY;
      VERIFY: begin
        if (match) begin
          if (stb_q == LAST_STB) state_d = PRESENT;
        end else if (ret_q < RET_MAX) begin
          state_d = SCAN;
        end else begin
          state_d = PRESENT;
        end
      end
      PRESENT: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_q <= '0;
      shv_q  <= '0;
      she_q  <= '0;
      val_q  <= '0;
      err_q  <= '0;
      unst_q <= 1'b0;
      idx_q  <= '0;
      stb_q  <= '0;
      ret_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            snap_q <= hex_in;
            idx_q  <= '0;
            ret_q  <= '0;
          end
        end
        SCAN: begin
          shv_q[idx_q] <= dec[3:0];
          she_q[idx_q] <= dec[4];
          idx_q        <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) stb_q <= '0;
        end
        VERIFY: begin
          if (match) begin
            if (stb_q == LAST_STB) begin
              val_q  <= shv_q;
              err_q  <= she_q;
              unst_q <= 1'b0;
            end else begin
              stb_q <= stb_q + 1'b1;
            end
          end else if (ret_q < RET_MAX) begin
            // Input moved under us: restart the decode on the new value.
            snap_q <= hex_in;
            ret_q  <= ret_q + 1'b1;
            idx_q  <= '0;
            stb_q  <= '0;
          end else begin
            // Out of retries: hand over the last decode, flagged.
            val_q  <= shv_q;
            err_q  <= she_q;
            unst_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_pattern_decoder.sv
module tb_hex_pattern_decoder;
  localparam int ND = 6;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            start = 1'b0;
  logic            out_ready = 1'b0;
  logic [ND*7-1:0] hex_in = '0;
  logic            busy, out_valid, unstable;
  logic [ND*4-1:0] value_out;
  logic [ND-1:0]   digit_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [ND*7-1:0] hx;
    logic [ND*4-1:0] ev;
    logic [ND-1:0]   ee;
  } vec_t;

  vec_t vecs[$];
  logic [6:0] seg [16];

  localparam logic [ND*7-1:0] PA = {7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h0E}; // 1234AF
  localparam logic [ND*7-1:0] PB = {7'h46, 7'h21, 7'h06, 7'h00, 7'h10, 7'h03}; // CDE89B

  always #5 clk = ~clk;

  hex_pattern_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(4), .MAX_RETRIES(3)) dut (
    .clk(clk), .reset_n(reset_n), .hex_in(hex_in), .start(start), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .value_out(value_out),
    .digit_err(digit_err), .unstable(unstable)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // Drive start for one edge; cyc counts edges after the sampling edge.
  task automatic launch(input logic [ND*7-1:0] hx);
    @(negedge clk);
    hex_in = hx;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cyc    = 0;
  endtask

  task automatic wait_valid();
    while (!out_valid && cyc < 200) step();
  endtask

  task automatic accept();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    launch(v.hx);
    wait_valid();
    chk({nm, "/latency"}, 64'(cyc), 64'd10);
    chk({nm, "/value"}, 64'(value_out), 64'(v.ev));
    chk({nm, "/err"}, 64'(digit_err), 64'(v.ee));
    chk({nm, "/unstable"}, 64'(unstable), 64'd0);
    accept();
    chk({nm, "/busy_after"}, 64'({busy, out_valid}), 64'd0);
  endtask

  initial begin
    vec_t v;
    bit   ok;
    seg = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    v.hx = PA; v.ev = 24'h1234AF; v.ee = 6'b000000; vecs.push_back(v);
    v.hx = PB; v.ev = 24'hCDE89B; v.ee = 6'b000000; vecs.push_back(v);
    v.hx = {ND{7'h7F}}; v.ev = 24'h000000; v.ee = 6'b111111; vecs.push_back(v);
    v.hx = {7'h46, 7'h21, 7'h55, 7'h00, 7'h10, 7'h03};
    v.ev = 24'hCD089B; v.ee = 6'b001000; vecs.push_back(v);
    for (int i = 0; i < 16; i++) begin
      v.hx = {7'h79, 7'h24, 7'h30, 7'h19, 7'h7F, seg[i]};
      v.ev = {16'h1234, 4'h0, 4'(i)};
      v.ee = 6'b000010;
      vecs.push_back(v);
    end

    // Reset state
    #12;
    chk("reset/outs", 64'({busy, out_valid, unstable, digit_err, value_out}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Input changes on the second VERIFY cycle -> one rescan, +8 cycles
    launch(PA);
    while (cyc < 7) step();
    hex_in = PB;
    wait_valid();
    chk("rescan/latency", 64'(cyc), 64'd18);
    chk("rescan/value", 64'(value_out), 64'hCDE89B);
    chk("rescan/unstable", 64'(unstable), 64'd0);
    accept();

    // Toggling input: four mismatches, last snapshot (PB) presented, flagged
    launch(PA);
    while (!out_valid && cyc < 200) begin
      hex_in = (hex_in == PA) ? PB : PA;
      step();
    end
    hex_in = PA;
    chk("toggle/latency", 64'(cyc), 64'd28);
    chk("toggle/unstable", 64'(unstable), 64'd1);
    chk("toggle/value", 64'(value_out), 64'hCDE89B);
    accept();

    // start during SCAN/VERIFY/PRESENT ignored; PRESENT holds with ready low
    launch(PA);
    while (cyc < 2) step();
    start = 1'b1; step(); start = 1'b0;
    while (cyc < 8) step();
    start = 1'b1; step(); start = 1'b0;
    wait_valid();
    chk("hold/latency", 64'(cyc), 64'd10);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      start = (i == 5);
      step();
      if (!(out_valid && busy && value_out == 24'h1234AF && digit_err == '0 && !unstable))
        ok = 1'b0;
    end
    start = 1'b0;
    chk("hold/stable20", 64'(ok), 64'd1);
    out_ready = 1'b1; start = 1'b1;
    step();
    out_ready = 1'b0; start = 1'b0;
    chk("hold/idle_after_ready", 64'({busy, out_valid}), 64'd0);
    step();
    chk("hold/start_with_ready_ignored", 64'(busy), 64'd0);
    chk("hold/value_kept", 64'(value_out), 64'h1234AF);

    // Asynchronous reset mid-SCAN
    launch(PB);
    step(); step();
    #2 reset_n = 1'b0;
    #1;
    chk("areset/outs", 64'({busy, out_valid, unstable, digit_err, value_out}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_vec("after_reset", vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
